mix_col_engine: RTL and testbench
=================================

MIX_COL_ENGINE -- requirements
Module: mix_col_engine

Interface
REQ-001 The parameter list SHALL be: COLS_PER_CYCLE, default 1, number of 32-bit state columns transformed per BUSY cycle; legal values are 1, 2 and 4.
REQ-002 The port list SHALL be: clk, input, 1, sole clock; all state changes occur on its rising edge.
REQ-003 The port list SHALL be: rst_n, input, 1, asynchronous active-low reset.
REQ-004 The port list SHALL be: in_valid, input, 1, a block is offered on in_data.
REQ-005 The port list SHALL be: in_ready, output, 1, the engine can accept a block.
REQ-006 The port list SHALL be: in_data, input, 128, AES state; column 0 = [127:96], column 3 = [31:0]; row 0 of each column in its MSB byte.
REQ-007 The port list SHALL be: in_inv, input, 1, selects InvMixColumns when 1 and MixColumns when 0; it is sampled with the block.
REQ-008 The port list SHALL be: out_valid, output, 1, a result is present on out_data.
REQ-009 The port list SHALL be: out_ready, input, 1, the consumer accepts the result.
REQ-010 The port list SHALL be: out_data, output, 128, transformed state with the same column and byte layout as in_data.

Function
REQ-011 Forward mode SHALL multiply each column by the circulant matrix {02,03,01,01} in GF(2^8) with polynomial 0x11B.
REQ-012 Inverse mode SHALL use the circulant matrix {0E,0B,0D,09} in GF(2^8) with polynomial 0x11B.
REQ-013 The engine SHALL implement three states:
- IDLE, empty;
- BUSY, transforming;
- DONE, holding a result.
REQ-014 A block SHALL be accepted on a rising edge where in_valid && in_ready; in_data and in_inv are captured into an internal state register, the beat counter clears to 0, and the state moves to BUSY.
REQ-015 In BUSY, each cycle SHALL transform columns [beat*C .. beat*C+C-1], where C = COLS_PER_CYCLE, in place in the state register, then increment the beat counter.
REQ-016 After beat N-1, where N = 4/C, the state SHALL move to DONE; out_valid is therefore first high exactly N cycles after the accepting edge (4, 2 or 1 cycles).
REQ-017 out_valid SHALL be 1 only in DONE, and out_data SHALL be the state register, held stable while out_valid && !out_ready.
REQ-018 A result SHALL be consumed on a rising edge where out_valid && out_ready; the state then moves to IDLE, unless REQ-020 applies.
REQ-019 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready), and it is 0 throughout BUSY.
REQ-020 When a result is consumed and a new block is accepted on the same edge, the engine SHALL go directly DONE->BUSY with the new block; no bubble is allowed.
REQ-021 Changes to in_data or in_inv after acceptance SHALL have no effect on the block in flight.
REQ-022 The sustained throughput SHALL be one block per N+1 cycles with out_ready held high.
REQ-023 out_data SHALL contain no X values after reset, even before the first block has been accepted.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force state IDLE, beat counter 0, out_valid 0, and out_data 128'h0; in_ready is 1 while in reset.
REQ-025 Reset during BUSY or DONE SHALL discard the block in flight, and no out_valid follows deassertion.
REQ-026 Deassertion SHALL be treated as synchronous to clk by the surrounding system; the engine needs no internal synchroniser.

Structure
REQ-027 A shared package aes_pkg SHALL hold:
- the GF polynomial constant 8'h1B;
- the forward and inverse coefficient sets;
- the state enumeration;
- the xtime function.
REQ-028 The natural sub-module SHALL be gf_col_mix, a combinational one-column transform with a mode input, instantiated COLS_PER_CYCLE times.
REQ-029 An illegal COLS_PER_CYCLE value SHALL cause an elaboration-time error.
REQ-030 The whole design SHALL contain no latches, and the only registers SHALL be the state register, beat counter, state FSM and mode bit.

Verification
REQ-031 The bench SHALL cover the forward vector: in_data=db135345f20a225c01010101c6c6c6c6, in_inv=0 -> out_data=8e4da1bc9fdc589d01010101c6c6c6c6.
REQ-032 The bench SHALL cover the inverse vector: in_data=8e4da1bc9fdc589d01010101c6c6c6c6, in_inv=1 -> out_data=db135345f20a225c01010101c6c6c6c6.
REQ-033 The bench SHALL cover latency for each COLS_PER_CYCLE in {1,2,4}: out_valid rises exactly 4, 2 and 1 cycles respectively after the accepting edge, and in_ready is 0 during BUSY.
REQ-034 The bench SHALL cover back-pressure: with out_ready=0 for 5 cycles in DONE, out_data remains stable and in_ready stays 0; out_ready=1 with in_valid=1 accepts the next block on the same edge (REQ-020).
REQ-035 The bench SHALL cover reset mid-BUSY: rst_n pulsed low at beat 1 -> out_valid=0 and out_data=0 immediately, and no result appears afterwards.
REQ-036 The bench SHALL cover a round trip: 1000 random blocks, forward then inverse, return the original block, checked against a reference model.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared GF(2^8) constants, coefficient sets, FSM encoding and byte-multiply helpers
// for the MixColumns engine.
package aes_pkg;

    localparam logic [7:0] GF_POLY = 8'h1B;

    // Element k is the coefficient applied to byte (r + k) mod 4 when producing row r.
    localparam logic [7:0] FWD_COEF [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    localparam logic [7:0] INV_COEF [4] = '{8'h0E, 8'h0B, 8'h0D, 8'h09};

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } mc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/gf_col_mix.sv
// Combinational transform of one 32-bit AES state column (row 0 in the MSB byte);
// inv_i selects InvMixColumns.
module gf_col_mix
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    input  logic        inv_i,
    output logic [31:0] col_o
);

    function automatic logic [31:0] mix(input logic [31:0] col, input logic [7:0] coef [4]);
        logic [31:0] res;
        logic [7:0]  acc;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) begin
                acc = acc ^ gf_mul(col[31 - 8 * j -: 8], coef[(j - r + 4) % 4]);
            end
            res[31 - 8 * r -: 8] = acc;
        end
        return res;
    endfunction

    assign col_o = inv_i ? mix(col_i, INV_COEF) : mix(col_i, FWD_COEF);

endmodule

// File: rtl/mix_col_engine.sv
// Multi-cycle AES (Inv)MixColumns engine: transforms COLS_PER_CYCLE columns per cycle
// in place, then holds the result under a valid/ready handshake.
module mix_col_engine
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_col_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam int unsigned NumBeats = 4 / COLS_PER_CYCLE;
    localparam logic [1:0]  LastBeat = 2'(NumBeats - 1);

    mc_state_e    fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [1:0]   beat_q, beat_d;
    logic         inv_q, inv_d;

    logic [1:0]  col_idx [COLS_PER_CYCLE];
    logic [31:0] col_in  [COLS_PER_CYCLE];
    logic [31:0] col_out [COLS_PER_CYCLE];

    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
        assign col_idx[i] = 2'((32'(beat_q) * COLS_PER_CYCLE + i) % 4);
        // Column k lives at bits [127-32k -: 32], i.e. base offset 32*(3-k).
        assign col_in[i]  = state_q[{~col_idx[i], 5'b0} +: 32];

        gf_col_mix u_mix (
            .col_i (col_in[i]),
            .inv_i (inv_q),
            .col_o (col_out[i])
        );
    end

    logic accept;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        beat_d  = beat_q;
        inv_d   = inv_q;

        out_valid = (fsm_q == StDone);
        in_ready  = (fsm_q == StIdle) || ((fsm_q == StDone) && out_ready);
        accept    = in_valid && in_ready;

        case (fsm_q)
            StIdle: ;
            StBusy: begin
                for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                    state_d[{~col_idx[i], 5'b0} +: 32] = col_out[i];
                end
                if (beat_q == LastBeat) begin
                    fsm_d  = StDone;
                    beat_d = '0;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            StDone: begin
                if (out_ready) fsm_d = StIdle;
            end
            default: fsm_d = StIdle;
        endcase

        // Load overrides the DONE->IDLE exit so a consume+accept edge has no bubble.
        if (accept) begin
            state_d = in_data;
            inv_d   = in_inv;
            beat_d  = '0;
            fsm_d   = StBusy;
        end
    end

    assign out_data = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= StIdle;
            state_q <= '0;
            beat_q  <= '0;
            inv_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            beat_q  <= beat_d;
            inv_q   <= inv_d;
        end
    end

endmodule

// File: tb/tb_mix_col_engine.sv
// Self-checking bench: three engines (1, 2 and 4 columns per cycle) driven in lockstep
// and compared against a plain-arithmetic GF(2^8) matrix model.
module tb_mix_col_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_ready;

    logic         rdy_w  [3];
    logic         vld_w  [3];
    logic [127:0] dout_w [3];

    int n_cmp = 0;
    int n_err = 0;
    int lat [3] = '{4, 2, 1};

    always #5 clk = ~clk;

    mix_col_engine #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[0]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(vld_w[0]),
        .out_ready(out_ready), .out_data(dout_w[0])
    );
    mix_col_engine #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[1]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(vld_w[1]),
        .out_ready(out_ready), .out_data(dout_w[1])
    );
    mix_col_engine #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[2]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(vld_w[2]),
        .out_ready(out_ready), .out_data(dout_w[2])
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Russian-peasant multiply modulo x^8+x^4+x^3+x+1.
    function automatic int ref_mul(input int a, input int b);
        int p = 0;
        while (b != 0) begin
            if ((b & 1) != 0) p = p ^ a;
            a = a << 1;
            if ((a & 'h100) != 0) a = a ^ 'h11B;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] blk, input bit inv);
        int c [4];
        int acc;
        logic [127:0] res = '0;
        if (inv) c = '{14, 11, 13, 9};
        else     c = '{2, 3, 1, 1};
        for (int col = 0; col < 4; col++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 0;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ ref_mul(int'(blk[127 - 32 * col - 8 * j -: 8]), c[(j - r + 4) % 4]);
                end
                res[127 - 32 * col - 8 * r -: 8] = acc[7:0];
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offers a block at the current cycle; returns #1 after the accepting edge.
    task automatic accept_block(input logic [127:0] data, input bit inv);
        in_valid = 1'b1;
        in_data  = data;
        in_inv   = inv;
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("rdy_offer[%0d]", i), rdy_w[i], 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = rand128();
        in_inv   = ~inv;
    endtask

    // Walks cycles 0..4 after acceptance with out_ready low, then checks the result.
    task automatic wait_result(input logic [127:0] exp, input bit detail);
        for (int k = 0; k <= 4; k++) begin
            if (detail) begin
                for (int i = 0; i < 3; i++) begin
                    check($sformatf("vld[%0d]@%0d", i, k), vld_w[i], (k >= lat[i]) ? 1'b1 : 1'b0);
                    check($sformatf("rdy[%0d]@%0d", i, k), rdy_w[i], 1'b0);
                end
            end
            if (k < 4) begin
                @(posedge clk);
                #1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("vld_end[%0d]", i), vld_w[i], 1'b1);
            check($sformatf("data[%0d]", i), dout_w[i], exp);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) check($sformatf("vld_drain[%0d]", i), vld_w[i], 1'b0);
    endtask

    logic [127:0] vec_a, vec_b, blk, fwd, nxt;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_inv    = 1'b0;
        out_ready = 1'b0;
        vec_a     = 128'hdb135345f20a225c01010101c6c6c6c6;
        vec_b     = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

        #2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_vld[%0d]", i), vld_w[i], 1'b0);
            check($sformatf("rst_data[%0d]", i), dout_w[i], 128'h0);
            check($sformatf("rst_rdy[%0d]", i), rdy_w[i], 1'b1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        accept_block(vec_a, 1'b0);
        wait_result(vec_b, 1'b1);
        check("model_fwd_vec", ref_mix(vec_a, 1'b0), vec_b);
        drain();
        accept_block(vec_b, 1'b1);
        wait_result(vec_a, 1'b1);

        // Back-pressure: hold the result, then consume and accept on the same edge.
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("bp_data[%0d]", i), dout_w[i], vec_a);
                check($sformatf("bp_vld[%0d]", i), vld_w[i], 1'b1);
                check($sformatf("bp_rdy[%0d]", i), rdy_w[i], 1'b0);
            end
        end
        nxt = rand128();
        out_ready = 1'b1;
        accept_block(nxt, 1'b0);
        out_ready = 1'b0;
        wait_result(ref_mix(nxt, 1'b0), 1'b1);
        drain();

        // Reset while BUSY at beat 1.
        accept_block(rand128(), 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("midrst_vld[%0d]", i), vld_w[i], 1'b0);
            check($sformatf("midrst_data[%0d]", i), dout_w[i], 128'h0);
            check($sformatf("midrst_rdy[%0d]", i), rdy_w[i], 1'b1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) check($sformatf("postrst_vld[%0d]", i), vld_w[i], 1'b0);
        end

        // Random round trips.
        for (int n = 0; n < 1000; n++) begin
            blk = rand128();
            fwd = ref_mix(blk, 1'b0);
            accept_block(blk, 1'b0);
            wait_result(fwd, n < 20);
            drain();
            accept_block(fwd, 1'b1);
            wait_result(blk, n < 20);
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
